// File: rtl/fifo_cpu_regs.sv
// fifo_cpu_regs: CPU configuration-bus register file that controls and observes a
// first-word-fall-through FIFO.
//
// Build option: define FIFO_CPU_REGS_IRQ_EN to include the sticky FLAGS register
// (OVF/UNF/THR), CTRL.irq_en and the irq output. Without it, address 0x5 reads 0,
// CTRL bit2 reads 0 and irq is tied low.
//
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   CS, Rd_Wr, Addr   single-cycle bus access: CS=1 qualifies, Rd_Wr=1 read / 0 write
//   DataIn, DataOut   write data / registered read data (0 when the previous cycle
//                     was not a read)
//   fifo_wr_en/data   one-cycle push strobe and its data
//   fifo_rd_en        one-cycle pop strobe
//   fifo_rd_data      FIFO head (FWFT)
//   fifo_count        occupancy, CNT_W+1 bits
//   fifo_full/empty   FIFO status
//   fifo_clr          one-cycle flush strobe
//   irq               registered level interrupt
//
// Register map: 0x0 CTRL, 0x1 STATUS, 0x2 COUNT, 0x3 THRESH, 0x4 DATA, 0x5 FLAGS (W1C).
module fifo_cpu_regs #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             CS,
  input  logic             Rd_Wr,
  input  logic [3:0]       Addr,
  input  logic [7:0]       DataIn,
  output logic [7:0]       DataOut,
  output logic             fifo_wr_en,
  output logic [7:0]       fifo_wr_data,
  output logic             fifo_rd_en,
  input  logic [7:0]       fifo_rd_data,
  input  logic [CNT_W:0]   fifo_count,
  input  logic             fifo_full,
  input  logic             fifo_empty,
  output logic             fifo_clr,
  output logic             irq
);

  localparam logic [3:0] AddrCtrl   = 4'h0;
  localparam logic [3:0] AddrStatus = 4'h1;
  localparam logic [3:0] AddrCount  = 4'h2;
  localparam logic [3:0] AddrThresh = 4'h3;
  localparam logic [3:0] AddrData   = 4'h4;
  localparam logic [3:0] AddrFlags  = 4'h5;

  logic       wr_acc, rd_acc;
  logic       push_ok, pop_ok;
  logic       thr_cond;
  logic [7:0] count_ext;
  logic [7:0] rdata;

  logic       enable_q;
  logic [7:0] thresh_q;
  logic       irq_en_q;
  logic [2:0] flags_q;

  assign wr_acc    = CS & ~Rd_Wr;
  assign rd_acc    = CS & Rd_Wr;
  // Full/empty are taken as sampled at the access edge.
  assign push_ok   = enable_q & ~fifo_full;
  assign pop_ok    = enable_q & ~fifo_empty;
  assign count_ext = 8'(fifo_count);
  assign thr_cond  = (count_ext >= thresh_q);

  always_comb begin
    rdata = 8'h00;
    case (Addr)
      AddrCtrl:   rdata = {5'b0, irq_en_q, 1'b0, enable_q};
      AddrStatus: rdata = {5'b0, thr_cond, fifo_full, fifo_empty};
      AddrCount:  rdata = count_ext;
      AddrThresh: rdata = thresh_q;
      AddrData:   rdata = pop_ok ? fifo_rd_data : 8'h00;
      AddrFlags:  rdata = {5'b0, flags_q};
      default:    rdata = 8'h00;
    endcase
  end

  // Bus-facing outputs and plain control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      DataOut      <= 8'h00;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= 8'h00;
      fifo_rd_en   <= 1'b0;
      fifo_clr     <= 1'b0;
      enable_q     <= 1'b0;
      thresh_q     <= 8'd8;
    end else begin
      DataOut    <= rd_acc ? rdata : 8'h00;
      fifo_wr_en <= wr_acc && (Addr == AddrData) && push_ok;
      fifo_rd_en <= rd_acc && (Addr == AddrData) && pop_ok;
      fifo_clr   <= wr_acc && (Addr == AddrCtrl) && DataIn[1];
      if (wr_acc && (Addr == AddrData) && push_ok) begin
        fifo_wr_data <= DataIn;
      end
      if (wr_acc && (Addr == AddrCtrl)) begin
        enable_q <= DataIn[0];
      end
      if (wr_acc && (Addr == AddrThresh)) begin
        thresh_q <= DataIn;
      end
    end
  end

`ifdef FIFO_CPU_REGS_IRQ_EN
  logic       thr_hist_q;
  logic       ovf_set, unf_set, thr_set;
  logic [2:0] w1c;
  logic [2:0] flags_d;

  assign ovf_set = wr_acc && (Addr == AddrData) && !push_ok;
  assign unf_set = rd_acc && (Addr == AddrData) && !pop_ok;
  // THR fires only on the cycle the threshold condition becomes true.
  assign thr_set = thr_cond & ~thr_hist_q;
  assign w1c     = (wr_acc && (Addr == AddrFlags)) ? DataIn[2:0] : 3'b000;
  // A set event in the same cycle as a clear wins.
  assign flags_d = (flags_q & ~w1c) | {thr_set, unf_set, ovf_set};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q    <= 3'b000;
      irq_en_q   <= 1'b0;
      thr_hist_q <= 1'b0;
    end else begin
      flags_q    <= flags_d;
      thr_hist_q <= thr_cond;
      if (wr_acc && (Addr == AddrCtrl)) begin
        irq_en_q <= DataIn[2];
      end
    end
  end
`else
  assign flags_q  = 3'b000;
  assign irq_en_q = 1'b0;
`endif

  // irq follows register state with one cycle of lag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else begin
      irq <= irq_en_q & (|flags_q);
    end
  end

endmodule

// File: tb/tb_fifo_cpu_regs.sv
module tb_fifo_cpu_regs;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       CS;
  logic       Rd_Wr;
  logic [3:0] Addr;
  logic [7:0] DataIn;
  logic [7:0] DataOut;
  logic       fifo_wr_en;
  logic [7:0] fifo_wr_data;
  logic       fifo_rd_en;
  logic [7:0] fifo_rd_data;
  logic [4:0] fifo_count;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_clr;
  logic       irq;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fifo_cpu_regs #(.CNT_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .CS           (CS),
    .Rd_Wr        (Rd_Wr),
    .Addr         (Addr),
    .DataIn       (DataIn),
    .DataOut      (DataOut),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_count   (fifo_count),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .fifo_clr     (fifo_clr),
    .irq          (irq)
  );

  // Inputs change and outputs are sampled on the falling edge. On return the
  // outputs produced by the access edge are visible.
  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    CS = 1'b1; Rd_Wr = 1'b0; Addr = a; DataIn = d;
    @(negedge clk);
    CS = 1'b0; Rd_Wr = 1'b0; Addr = 4'h0; DataIn = 8'h00;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    CS = 1'b1; Rd_Wr = 1'b1; Addr = a;
    @(negedge clk);
    d = DataOut;
    CS = 1'b0; Rd_Wr = 1'b0; Addr = 4'h0;
  endtask

  task automatic test_reset();
    logic [7:0] r;
    rst_n = 1'b0;
    CS = 1'b0; Rd_Wr = 1'b0; Addr = 4'h0; DataIn = 8'h00;
    fifo_rd_data = 8'h00; fifo_count = 5'd0; fifo_full = 1'b0; fifo_empty = 1'b1;
    #12;
    n_cmp++;
    if ({DataOut, fifo_wr_en, fifo_rd_en, fifo_clr, irq, fifo_wr_data} !== 20'h0) begin
      n_bad++;
      $display("FAIL reset_outputs got DataOut=%h wr=%b rd=%b clr=%b irq=%b wdata=%h exp all 0",
               DataOut, fifo_wr_en, fifo_rd_en, fifo_clr, irq, fifo_wr_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus_read(4'h3, r);
    n_cmp++;
    if (r !== 8'h08) begin n_bad++; $display("FAIL reset_thresh got %h exp 08", r); end
    bus_read(4'h0, r);
    n_cmp++;
    if (r !== 8'h00) begin n_bad++; $display("FAIL reset_ctrl got %h exp 00", r); end
    @(negedge clk);
    n_cmp++;
    if (DataOut !== 8'h00) begin
      n_bad++; $display("FAIL dataout_idle got %h exp 00", DataOut);
    end
  endtask

  task automatic test_push_pop();
    logic [7:0] r;
    bus_write(4'h0, 8'h01);
    bus_write(4'h4, 8'hA5);
    n_cmp++;
    if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'hA5) begin
      n_bad++; $display("FAIL push got wr_en=%b data=%h exp 1/a5", fifo_wr_en, fifo_wr_data);
    end
    @(negedge clk);
    n_cmp++;
    if (fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL push_one_cycle got %b exp 0", fifo_wr_en); end
    fifo_empty = 1'b0; fifo_count = 5'd1; fifo_rd_data = 8'hA5;
    bus_read(4'h4, r);
    n_cmp++;
    if (r !== 8'hA5 || fifo_rd_en !== 1'b1) begin
      n_bad++; $display("FAIL pop got data=%h rd_en=%b exp a5/1", r, fifo_rd_en);
    end
    @(negedge clk);
    n_cmp++;
    if (fifo_rd_en !== 1'b0 || DataOut !== 8'h00) begin
      n_bad++; $display("FAIL pop_one_cycle got rd_en=%b data=%h exp 0/00", fifo_rd_en, DataOut);
    end
    fifo_empty = 1'b1; fifo_count = 5'd0;
    // Back-to-back pushes give consecutive strobes.
    @(negedge clk);
    CS = 1'b1; Rd_Wr = 1'b0; Addr = 4'h4; DataIn = 8'h11;
    @(negedge clk);
    n_cmp++;
    if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'h11) begin
      n_bad++; $display("FAIL b2b_first got wr_en=%b data=%h exp 1/11", fifo_wr_en, fifo_wr_data);
    end
    DataIn = 8'h22;
    @(negedge clk);
    CS = 1'b0;
    n_cmp++;
    if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'h22) begin
      n_bad++; $display("FAIL b2b_second got wr_en=%b data=%h exp 1/22", fifo_wr_en, fifo_wr_data);
    end
    @(negedge clk);
    n_cmp++;
    if (fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL b2b_end got %b exp 0", fifo_wr_en); end
  endtask

  task automatic test_ovf_unf();
    logic [7:0] r;
    fifo_full = 1'b1; fifo_empty = 1'b0; fifo_count = 5'd2;
    bus_write(4'h4, 8'h33);
    n_cmp++;
    if (fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL ovf_no_strobe got %b exp 0", fifo_wr_en); end
`ifdef FIFO_CPU_REGS_IRQ_EN
    bus_read(4'h5, r);
    n_cmp++;
    if (r !== 8'h01) begin n_bad++; $display("FAIL ovf_flag got %h exp 01", r); end
`endif
    fifo_full = 1'b0; fifo_empty = 1'b1; fifo_count = 5'd0; fifo_rd_data = 8'h77;
    bus_read(4'h4, r);
    n_cmp++;
    if (r !== 8'h00 || fifo_rd_en !== 1'b0) begin
      n_bad++; $display("FAIL unf_read got data=%h rd_en=%b exp 00/0", r, fifo_rd_en);
    end
`ifdef FIFO_CPU_REGS_IRQ_EN
    bus_read(4'h5, r);
    n_cmp++;
    if (r !== 8'h03) begin n_bad++; $display("FAIL unf_flag got %h exp 03", r); end
    bus_write(4'h0, 8'h05);
    @(negedge clk);
    n_cmp++;
    if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_set got %b exp 1", irq); end
    bus_read(4'h0, r);
    n_cmp++;
    if (r !== 8'h05) begin n_bad++; $display("FAIL ctrl_irq_en got %h exp 05", r); end
    bus_write(4'h5, 8'h03);
    @(negedge clk);
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_clear got %b exp 0", irq); end
    bus_read(4'h5, r);
    n_cmp++;
    if (r !== 8'h00) begin n_bad++; $display("FAIL flags_w1c got %h exp 00", r); end
`else
    bus_write(4'h0, 8'h05);
    bus_read(4'h0, r);
    n_cmp++;
    if (r !== 8'h01) begin n_bad++; $display("FAIL ctrl_no_irq_en got %h exp 01", r); end
    bus_write(4'h5, 8'hFF);
    bus_read(4'h5, r);
    n_cmp++;
    if (r !== 8'h00) begin n_bad++; $display("FAIL flags_absent got %h exp 00", r); end
    fifo_full = 1'b1;
    bus_write(4'h4, 8'h44);
    @(negedge clk);
    n_cmp++;
    if (irq !== 1'b0 || fifo_wr_en !== 1'b0) begin
      n_bad++; $display("FAIL irq_tied got irq=%b wr_en=%b exp 0/0", irq, fifo_wr_en);
    end
    fifo_full = 1'b0;
`endif
  endtask

  task automatic test_threshold();
    logic [7:0] r;
    fifo_empty = 1'b0; fifo_full = 1'b0; fifo_count = 5'd2;
    bus_write(4'h3, 8'h03);
    bus_read(4'h1, r);
    n_cmp++;
    if (r !== 8'h00) begin n_bad++; $display("FAIL status_below got %h exp 00", r); end
    @(negedge clk);
    fifo_count = 5'd3;
    bus_read(4'h1, r);
    n_cmp++;
    if (r !== 8'h04) begin n_bad++; $display("FAIL status_at got %h exp 04", r); end
    bus_read(4'h2, r);
    n_cmp++;
    if (r !== 8'h03) begin n_bad++; $display("FAIL count_read got %h exp 03", r); end
`ifdef FIFO_CPU_REGS_IRQ_EN
    bus_read(4'h5, r);
    n_cmp++;
    if (r !== 8'h04) begin n_bad++; $display("FAIL thr_set got %h exp 04", r); end
    bus_write(4'h5, 8'h04);
    @(negedge clk);
    bus_read(4'h5, r);
    n_cmp++;
    if (r !== 8'h00) begin n_bad++; $display("FAIL thr_no_reset got %h exp 00", r); end
    @(negedge clk);
    fifo_count = 5'd2;
    // New crossing in the same cycle as the W1C: set wins.
    @(negedge clk);
    fifo_count = 5'd3;
    CS = 1'b1; Rd_Wr = 1'b0; Addr = 4'h5; DataIn = 8'h04;
    @(negedge clk);
    CS = 1'b0;
    bus_read(4'h5, r);
    n_cmp++;
    if (r !== 8'h04) begin n_bad++; $display("FAIL thr_set_wins got %h exp 04", r); end
    bus_write(4'h5, 8'h07);
`endif
    fifo_count = 5'd0; fifo_empty = 1'b1;
  endtask

  task automatic test_clear_disabled();
    logic [7:0] r;
    bus_write(4'h0, 8'h03);
    n_cmp++;
    if (fifo_clr !== 1'b1) begin n_bad++; $display("FAIL clr_pulse got %b exp 1", fifo_clr); end
    @(negedge clk);
    n_cmp++;
    if (fifo_clr !== 1'b0) begin n_bad++; $display("FAIL clr_one_cycle got %b exp 0", fifo_clr); end
    bus_read(4'h0, r);
    n_cmp++;
    if (r !== 8'h01) begin n_bad++; $display("FAIL ctrl_after_clr got %h exp 01", r); end
    bus_write(4'h0, 8'h00);
    fifo_full = 1'b0;
    bus_write(4'h4, 8'h5A);
    n_cmp++;
    if (fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL disabled_push got %b exp 0", fifo_wr_en); end
    fifo_empty = 1'b0; fifo_count = 5'd1; fifo_rd_data = 8'h99;
    bus_read(4'h4, r);
    n_cmp++;
    if (r !== 8'h00 || fifo_rd_en !== 1'b0) begin
      n_bad++; $display("FAIL disabled_pop got data=%h rd_en=%b exp 00/0", r, fifo_rd_en);
    end
`ifdef FIFO_CPU_REGS_IRQ_EN
    bus_read(4'h5, r);
    n_cmp++;
    if (r !== 8'h03) begin n_bad++; $display("FAIL disabled_flags got %h exp 03", r); end
`endif
    // Read-only and undecoded writes have no effect.
    bus_write(4'h1, 8'hFF);
    bus_write(4'h9, 8'hFF);
    bus_read(4'h3, r);
    n_cmp++;
    if (r !== 8'h03) begin n_bad++; $display("FAIL ro_write got %h exp 03", r); end
    bus_read(4'h9, r);
    n_cmp++;
    if (r !== 8'h00) begin n_bad++; $display("FAIL undecoded got %h exp 00", r); end
  endtask

  task automatic test_reset_mid_access();
    logic [7:0] r;
    bus_write(4'h0, 8'h01);
    fifo_full = 1'b0;
    bus_read(4'h3, r);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (DataOut !== 8'h00) begin n_bad++; $display("FAIL async_reset got %h exp 00", DataOut); end
    rst_n = 1'b1;
    bus_write(4'h0, 8'h01);
    @(negedge clk);
    CS = 1'b1; Rd_Wr = 1'b0; Addr = 4'h4; DataIn = 8'hC3;
    #2 rst_n = 1'b0;
    @(negedge clk);
    CS = 1'b0;
    rst_n = 1'b1;
    n_cmp++;
    if (fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_drop got %b exp 0", fifo_wr_en); end
    @(negedge clk);
    n_cmp++;
    if (fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_drop_after got %b exp 0", fifo_wr_en); end
    bus_read(4'h3, r);
    n_cmp++;
    if (r !== 8'h08) begin n_bad++; $display("FAIL reset_thresh_again got %h exp 08", r); end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_ovf_unf();
    test_threshold();
    test_clear_disabled();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
